// File: rtl/release_delay_pkg.sv
// ============================================================================
// Module : release_delay_pkg
// Brief  : State encoding and terminal-count compare-width rule shared by the
//          release-delay and assertion-delay blocks.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package release_delay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } rd_state_e;

  // Effective number of counter MSBs used for the terminal-count compare.
  function automatic int tc_cmp_width(input int nbits, input int cmp_msbits);
    return (cmp_msbits < nbits) ? cmp_msbits : nbits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/release_delay_if.sv
// ============================================================================
// Module : release_delay_if
// Brief  : Request/stretched-level signal bundle for release_delay.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface release_delay_if;
  logic clear;
  logic in;
  logic out;
  logic holding;
  logic out_fall;

  modport master (output clear, output in, input out, input holding, input out_fall);
  modport slave  (input clear, input in, output out, output holding, output out_fall);
endinterface

`default_nettype wire

// File: rtl/release_delay_cnt.sv
// ============================================================================
// Module : release_delay_cnt
// Brief  : Release counter with synchronous zero/increment and MSB-based
//          terminal-count detect.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module release_delay_cnt
  import release_delay_pkg::*;
#(
  parameter int NBITS          = 4,
  parameter int CMP_NUM_MSBITS = 4
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic zero,
  input  logic inc,
  output logic tc
);

  localparam int C = tc_cmp_width(NBITS, CMP_NUM_MSBITS);

  logic [NBITS-1:0] cnt_q;
  logic [NBITS-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (zero) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + NBITS'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Only the top C bits take part, so terminal count is 2**NBITS - 2**(NBITS-C).
  assign tc = &cnt_q[NBITS-1 -: C];

endmodule

`default_nettype wire

// File: rtl/release_delay.sv
// ============================================================================
// Module : release_delay
// Brief  : Stretches a request level: out rises one cycle after in, falls
//          about 2**NBITS cycles after in drops. Optional out_fall pulse is
//          enabled by defining RELEASE_DELAY_FALL_PULSE_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module release_delay
  import release_delay_pkg::*;
#(
  parameter int NBITS          = 4,
  parameter int CMP_NUM_MSBITS = 4
) (
  input  logic           CLK,
  input  logic           RESET_N,
  release_delay_if.slave bus
);

  rd_state_e state_q;
  rd_state_e state_d;
  logic      out_q;
  logic      out_d;
  logic      holding_q;
  logic      holding_d;
  logic      out_fall_d;
  logic      cnt_zero;
  logic      cnt_inc;
  logic      cnt_tc;

  release_delay_cnt #(
    .NBITS          (NBITS),
    .CMP_NUM_MSBITS (CMP_NUM_MSBITS)
  ) u_cnt (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .zero    (cnt_zero),
    .inc     (cnt_inc),
    .tc      (cnt_tc)
  );

  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    holding_d  = holding_q;
    out_fall_d = 1'b0;
    cnt_zero   = 1'b0;
    cnt_inc    = 1'b0;
    if (bus.clear) begin
      state_d    = ST_IDLE;
      out_d      = 1'b0;
      holding_d  = 1'b0;
      cnt_zero   = 1'b1;
      out_fall_d = out_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_zero  = 1'b1;
          holding_d = 1'b0;
          out_d     = bus.in;
          if (bus.in) state_d = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          cnt_zero  = 1'b1;
          out_d     = 1'b1;
          holding_d = !bus.in;
          if (!bus.in) state_d = ST_HOLD;
        end
        ST_HOLD: begin
          // Re-trigger keeps out high and restarts the hold window.
          if (bus.in) begin
            state_d   = ST_ACTIVE;
            cnt_zero  = 1'b1;
            out_d     = 1'b1;
            holding_d = 1'b0;
          end else if (cnt_tc) begin
            state_d    = ST_IDLE;
            cnt_zero   = 1'b1;
            out_d      = 1'b0;
            holding_d  = 1'b0;
            out_fall_d = 1'b1;
          end else begin
            cnt_inc   = 1'b1;
            out_d     = 1'b1;
            holding_d = 1'b1;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          cnt_zero  = 1'b1;
          out_d     = 1'b0;
          holding_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      out_q     <= 1'b0;
      holding_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      holding_q <= holding_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.holding = holding_q;

`ifdef RELEASE_DELAY_FALL_PULSE_EN
  logic out_fall_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_fall_q <= 1'b0;
    end else begin
      out_fall_q <= out_fall_d;
    end
  end

  assign bus.out_fall = out_fall_q;
`else
  logic unused_out_fall;
  assign unused_out_fall = out_fall_d;
  assign bus.out_fall    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_release_delay.sv
// ============================================================================
// Module : tb_release_delay
// Brief  : Scoreboard bench for release_delay across three parameter sets
//          (4/4, 6/2, 1/1) sharing one stimulus stream.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_release_delay;

`ifdef RELEASE_DELAY_FALL_PULSE_EN
  localparam bit FALL_EN = 1'b1;
`else
  localparam bit FALL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] out;
    logic [2:0] hold;
    logic [2:0] fall;
  } exp_t;

  logic clk;
  logic rst_n;

  release_delay_if bus_a ();
  release_delay_if bus_b ();
  release_delay_if bus_c ();

  release_delay #(.NBITS(4), .CMP_NUM_MSBITS(4)) u_a (.CLK(clk), .RESET_N(rst_n), .bus(bus_a));
  release_delay #(.NBITS(6), .CMP_NUM_MSBITS(2)) u_b (.CLK(clk), .RESET_N(rst_n), .bus(bus_b));
  release_delay #(.NBITS(1), .CMP_NUM_MSBITS(1)) u_c (.CLK(clk), .RESET_N(rst_n), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  // Terminal counts: 2**NBITS - 2**(NBITS-C) for each instance
  int   m_tc [3] = '{15, 48, 1};
  bit   m_out [3];
  bit   m_hold[3];
  int   m_cnt [3];

  int   run_a;
  int   run_b;
  int   falls_a;
  int   falls_b;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_out[k]  = 1'b0;
      m_hold[k] = 1'b0;
      m_cnt[k]  = 0;
    end
  endtask

  task automatic drive(input logic c, input logic i);
    exp_t e;
    @(negedge clk);
    bus_a.clear = c; bus_a.in = i;
    bus_b.clear = c; bus_b.in = i;
    bus_c.clear = c; bus_c.in = i;
    e = '0;
    for (int k = 0; k < 3; k++) begin
      if (c) begin
        e.fall[k] = m_out[k];
        m_out[k]  = 1'b0;
        m_hold[k] = 1'b0;
        m_cnt[k]  = 0;
      end else if (i) begin
        m_out[k]  = 1'b1;
        m_hold[k] = 1'b0;
        m_cnt[k]  = 0;
      end else if (m_out[k]) begin
        if (!m_hold[k]) begin
          m_hold[k] = 1'b1;
          m_cnt[k]  = 0;
        end else if (m_cnt[k] == m_tc[k]) begin
          m_out[k]  = 1'b0;
          m_hold[k] = 1'b0;
          m_cnt[k]  = 0;
          e.fall[k] = 1'b1;
        end else begin
          m_cnt[k]++;
        end
      end
      e.out[k]  = m_out[k];
      e.hold[k] = m_hold[k];
      if (!FALL_EN) e.fall[k] = 1'b0;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("out_a",  bus_a.out,      e.out[0]);
    check_eq("hold_a", bus_a.holding,  e.hold[0]);
    check_eq("fall_a", bus_a.out_fall, e.fall[0]);
    check_eq("out_b",  bus_b.out,      e.out[1]);
    check_eq("hold_b", bus_b.holding,  e.hold[1]);
    check_eq("fall_b", bus_b.out_fall, e.fall[1]);
    check_eq("out_c",  bus_c.out,      e.out[2]);
    check_eq("hold_c", bus_c.holding,  e.hold[2]);
    check_eq("fall_c", bus_c.out_fall, e.fall[2]);
    if (!i && bus_a.out) run_a++;
    if (!i && bus_b.out) run_b++;
    if (bus_a.out_fall) falls_a++;
    if (bus_b.out_fall) falls_b++;
  endtask

  task automatic idle_n(input int n, input logic i);
    for (int k = 0; k < n; k++) drive(1'b0, i);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus_a.clear = 1'b0; bus_a.in = 1'b0;
    bus_b.clear = 1'b0; bus_b.in = 1'b0;
    bus_c.clear = 1'b0; bus_c.in = 1'b0;
    model_reset();
    #3;
    check_eq("rst_out",  bus_a.out,      0);
    check_eq("rst_hold", bus_a.holding,  0);
    check_eq("rst_fall", bus_a.out_fall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_n(2, 1'b0);

    // Basic stretch: in high 5 cycles, then low long enough for all to release
    run_a = 0; run_b = 0; falls_a = 0; falls_b = 0;
    idle_n(5, 1'b1);
    idle_n(60, 1'b0);
    check_eq("stretch_len_a", run_a, 16);
    check_eq("stretch_len_b", run_b, 49);
    check_eq("fall_count_a", falls_a, FALL_EN ? 1 : 0);
    check_eq("fall_count_b", falls_b, FALL_EN ? 1 : 0);

    // Coarse compare: single-cycle pulse on in
    run_b = 0; falls_b = 0;
    idle_n(1, 1'b1);
    idle_n(55, 1'b0);
    check_eq("pulse_len_b", run_b, 49);
    check_eq("pulse_fall_b", falls_b, FALL_EN ? 1 : 0);

    // Re-trigger after 10 HOLD cycles
    idle_n(3, 1'b1);
    idle_n(10, 1'b0);
    idle_n(1, 1'b1);
    run_a = 0;
    idle_n(55, 1'b0);
    check_eq("retrig_len_a", run_a, 16);

    // Clear colliding with in while ACTIVE
    idle_n(3, 1'b1);
    drive(1'b1, 1'b1);
    check_eq("clr_out_a", bus_a.out, 0);
    drive(1'b0, 1'b1);
    check_eq("clr_rise_a", bus_a.out, 1);
    idle_n(55, 1'b0);

    // Async reset mid-HOLD with counter at 7
    idle_n(2, 1'b1);
    idle_n(8, 1'b0);
    check_eq("pre_rst_hold_a", bus_a.holding, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_a",  bus_a.out,      0);
    check_eq("arst_hold_a", bus_a.holding,  0);
    check_eq("arst_fall_a", bus_a.out_fall, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_n(3, 1'b0);
    idle_n(1, 1'b1);
    idle_n(20, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/release_delay.md
Name: release_delay

Overview:
- Complement of the assertion-delay block: 'out' asserts one cycle after 'in' asserts, and deasserts only after 'in' has stayed low for about 2**NBITS cycles.
- Used to stretch enable/busy signals across short gaps, so downstream logic such as clock-enable or power gating does not toggle on brief idle periods.
- Carries a synchronous clear and a status output showing the hold (release) phase.

Parameters:
- NBITS, 4, width of the release counter; nominal hold time is 2**NBITS cycles.
- CMP_NUM_MSBITS, 4, number of counter MSBs compared for terminal count. The effective compare width C = min(NBITS, CMP_NUM_MSBITS).

Ports:
- CLK  input  1  clock; all logic on posedge.
- RESET_N  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear; forces IDLE on the next edge.
- in  input  1  request level to be stretched.
- out  output  1  stretched level, registered.
- holding  output  1  high while in the HOLD state (out=1, in low, counting down).
- out_fall  output  1  single-cycle pulse when out deasserts; feature-dependent.

Behaviour:
- Reset (RESET_N=0, asynchronous): state=IDLE, counter=0, out=0, holding=0, out_fall=0.
- All outputs are registered. Terminal count is reached when counter[NBITS-1 -: C] is all ones, i.e. counter == M = 2**NBITS - 2**(NBITS-C).
- IDLE:
  - in=1 -> ACTIVE, out<=1 (latency 1 cycle from sampled in).
  - Otherwise stay; out=0.
- ACTIVE:
  - in=1 -> stay; counter held at 0.
  - in=0 -> HOLD, counter<=0, holding<=1, out stays 1.
- HOLD:
  - in=1 -> ACTIVE, counter<=0, holding<=0. out never glitches low on re-trigger.
  - Else if terminal count -> IDLE, out<=0, holding<=0, out_fall<=1 (if enabled).
  - Else counter<=counter+1.
- Hold timing: if in is first sampled low at edge E0, out falls at edge E0+M+1. With NBITS=4 and C=4 that is 16 cycles after E0; total out-high time after in falls is 2**NBITS cycles.
- out_fall is high for exactly one cycle and is cleared on the next edge unconditionally.
- clear=1 has priority over everything: state<=IDLE, counter<=0, out<=0, holding<=0. out_fall<=1 only if out was 1 at that edge (feature enabled).
  - If clear and in are both high in the same cycle, clear wins; out rises on the following edge if in is still 1.
- A 1-cycle pulse on in from IDLE produces out high for 1+M+1 cycles.
- Counter never wraps: it stops at M because the exit is taken first.
- Illegal state encodings recover to IDLE with out=0.
- Degenerate case NBITS=1, C=1: M=1, so out falls two edges after E0.

Optional Feature:
- Macro RELEASE_DELAY_FALL_PULSE_EN.
- Defined: the out_fall pulse generation described above is compiled in.
- Not defined: out_fall is tied to constant 0, its register is removed, and all other behaviour is identical.

Decomposition:
- Shared package/header: state encoding constants (IDLE=2'd0, ACTIVE=2'd1, HOLD=2'd2) and the terminal-count compare-width rule, shared with the assertion-delay block so both compute C identically.
- One natural sub-module, release_delay_cnt: NBITS counter with synchronous zero and increment, plus the MSB terminal-count compare. The FSM stays in the top level.

Test Plan:
- Reset: RESET_N=0 asynchronously mid-HOLD with counter=7 -> out=0, holding=0, out_fall=0 immediately, without waiting for a clock edge. After release, state is IDLE.
- Basic stretch, NBITS=4, C=4: in high 5 cycles then low -> out rises 1 cycle after in. out stays high exactly 16 cycles after in is first sampled low. holding is high for those cycles; out_fall pulses 1 cycle coincident with out falling.
- Coarse compare, NBITS=6, CMP_NUM_MSBITS=2: in high 1 cycle, then low -> M=48, so out falls at E0+49. No out_fall other than that single pulse.
- Re-trigger: in low for 10 cycles of HOLD (NBITS=4), then high 1 cycle, then low -> out never drops. The counter restarts, and out falls 16 cycles after the second falling sample.
- Clear priority: clear=1 and in=1 in the same cycle while ACTIVE -> next edge out=0, out_fall=1. The following edge (in still 1, clear=0) gives out=1.
- Feature off (RELEASE_DELAY_FALL_PULSE_EN undefined): rerun the basic stretch case -> out/holding timing unchanged and out_fall constant 0 throughout.
